// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and helpers
// for the handshaked word RAM responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  // Lane pattern legality for a write at offset addr_lo.
  function automatic logic be_lane_ok(
    input logic [3:0] be,
    input logic [1:0] addr_lo
  );
    logic ok;
    ok = 1'b1;
    unique case (1'b1)
      (be == BE_NONE): ok = 1'b0;
      (be == BE_WORD): ok = (addr_lo == 2'd0);
      $onehot(be):     ok = be[addr_lo];
      default:         ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// mem_byte_ram: word RAM with four byte lanes,
// per-lane write enables and a registered read.
module mem_byte_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Lane writes and read capture; read holds when idle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready request channel in front
// of a byte-lane RAM, with wait states and errors.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  req_t        req_q, cur;
  logic        range_bad, req_err, commit;
  logic        err_q, rd_ok_q;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_q;

  // With no wait states the access commits on the
  // accepting edge, so use live inputs while idle.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur = '{wr:    req_wr,
              addr:  req_addr,
              wdata: req_wdata,
              be:    req_be};
    end
  end

  assign range_bad = |cur.addr[31:ADDR_WIDTH+2];
  assign req_err   = range_bad |
    (cur.wr ? ~be_lane_ok(cur.be, cur.addr[1:0])
            : |cur.addr[1:0]);

  // Next state, wait count and handshake outputs.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_nx = WAIT;
            cnt_nx   = 4'd1;
          end else begin
            state_nx = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == WS) begin
          state_nx = RESP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign commit = (state_nx == RESP);
  assign ram_we = (commit && cur.wr && !req_err)
                ? cur.be : 4'b0000;
  assign ram_re = commit && !cur.wr && !req_err;

  // State register, wait counter and request latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req_valid) req_q <= cur;
    end
  end

  // Response status captured as the access commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (commit) begin
      err_q   <= req_err;
      rd_ok_q <= !cur.wr && !req_err;
    end
  end

  assign rsp_err   = err_q;
  assign rsp_rdata = rd_ok_q ? ram_q : '0;

  mem_byte_ram #(
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur.addr[ADDR_WIDTH+1:2]),
    .wdata (cur.wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus on three
// wait-state variants with a cycle model of the first.
module tb_mem_responder;

  localparam int AW   = 8;
  localparam int WS_M = 1;

  logic        clk = 0;
  logic        reset;
  logic        rv    [3];
  logic        wr    [3];
  logic [31:0] ad    [3];
  logic [31:0] wd    [3];
  logic [3:0]  be    [3];
  logic        rdy   [3];
  logic        rvld  [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        bsy   [3];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_wr(wr[0]), .req_addr(ad[0]),
    .req_wdata(wd[0]), .req_be(be[0]),
    .rsp_valid(rvld[0]), .rsp_rdata(rdata[0]),
    .rsp_err(err[0]), .busy(bsy[0]));

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_wr(wr[1]), .req_addr(ad[1]),
    .req_wdata(wd[1]), .req_be(be[1]),
    .rsp_valid(rvld[1]), .rsp_rdata(rdata[1]),
    .rsp_err(err[1]), .busy(bsy[1]));

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(4)) u4 (
    .clk(clk), .reset(reset),
    .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_wr(wr[2]), .req_addr(ad[2]),
    .req_wdata(wd[2]), .req_be(be[2]),
    .rsp_valid(rvld[2]), .rsp_rdata(rdata[2]),
    .rsp_err(err[2]), .busy(bsy[2]));

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- model of u1 ----------------
  typedef struct {
    bit          v;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          err;
    int          at;
  } pend_t;

  pend_t       pd;
  int          ready_from = 0;
  logic [31:0] last_rd = '0;
  bit          last_err = 0;
  bit          last_known = 1;
  logic [31:0] mm [int];
  int          rsp_seen = 0;

  function automatic bit mdl_err(bit w,
                                 logic [31:0] a,
                                 logic [3:0] b);
    int off;
    off = int'(a % 4);
    if (a >= 32'(1 << (AW + 2))) return 1;
    if (!w) return off != 0;
    if (b == 4'd0) return 1;
    if (b == 4'd15) return off != 0;
    if ($countones(b) == 1)
      return b != 4'(1 << off);
    return 0;
  endfunction

  task automatic mdl_commit();
    int w;
    logic [31:0] v;
    if (pd.wr && !pd.err) begin
      w = int'(pd.a / 4);
      v = mm.exists(w) ? mm[w] : 32'd0;
      for (int i = 0; i < 4; i++)
        if (pd.be[i]) v[8*i +: 8] = pd.d[8*i +: 8];
      mm[w] = v;
    end
  endtask

  always @(negedge clk) begin : model
    bit exp_vld;
    bit exp_rdy;
    int w;
    if (rvld[0]) rsp_seen++;
    exp_vld = 0;
    if (!reset) begin
      if (pd.v && cyc == pd.at) mdl_commit();
      pd.v       = 0;
      ready_from = 0;
      last_rd    = '0;
      last_err   = 0;
      last_known = 1;
      chk("m_rst_vld", 32'(rvld[0]), 0);
      chk("m_rst_busy", 32'(bsy[0]), 0);
      chk("m_rst_rdata", rdata[0], 0);
      chk("m_rst_err", 32'(err[0]), 0);
    end else begin
      exp_rdy = (cyc >= ready_from);
      if (pd.v && cyc == pd.at) begin
        exp_vld    = 1;
        last_err   = pd.err;
        last_rd    = '0;
        last_known = 1;
        if (!pd.err && !pd.wr) begin
          w = int'(pd.a / 4);
          if (mm.exists(w)) last_rd = mm[w];
          else last_known = 0;
        end
        mdl_commit();
        pd.v = 0;
      end
      chk("m_vld", 32'(rvld[0]), 32'(exp_vld));
      chk("m_ready", 32'(rdy[0]), 32'(exp_rdy));
      chk("m_busy", 32'(bsy[0]), 32'(!exp_rdy));
      chk("m_err", 32'(err[0]), 32'(last_err));
      if (last_known)
        chk("m_rdata", rdata[0], last_rd);
      if (rv[0] && exp_rdy) begin
        pd.v   = 1;
        pd.wr  = wr[0];
        pd.a   = ad[0];
        pd.d   = wd[0];
        pd.be  = be[0];
        pd.err = mdl_err(wr[0], ad[0], be[0]);
        pd.at  = cyc + 1 + WS_M;
        ready_from = cyc + 2 + WS_M;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int i, input bit w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] b,
                       output int acc);
    int n;
    rv[i] = 1; wr[i] = w; ad[i] = a;
    wd[i] = d; be[i] = b;
    n = 0;
    @(negedge clk);
    while (!rdy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got %0d want <50", n);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    rv[i] = 0;
  endtask

  task automatic txn(input string nm, input int i,
                     input bit w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] b,
                     input logic [31:0] x_rd,
                     input bit x_er,
                     input int x_lat);
    int acc, n;
    issue(i, w, a, d, b, acc);
    n = 0;
    @(negedge clk);
    while (!rvld[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got none want rsp", nm);
    end else begin
      chk({nm, "_lat"}, 32'(cyc + 1 - acc), 32'(x_lat));
      chk({nm, "_err"}, 32'(err[i]), 32'(x_er));
      chk({nm, "_data"}, rdata[i], x_rd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, base;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 0; wr[i] = 0; ad[i] = '0;
      wd[i] = '0; be[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 1);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_vld", 32'(rvld[0]), 0);
    chk("rst_rdata", rdata[0], 0);
    @(posedge clk);
    #1;

    txn("w10", 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2);
    txn("r10", 0, 0, 32'h10, 0, 4'h0, 32'hDEADBEEF, 0, 2);
    txn("wb11", 0, 1, 32'h11, 32'h0000AA00, 4'b0010, 0, 0, 2);
    txn("r10b", 0, 0, 32'h10, 0, 4'h0, 32'hDEADAAEF, 0, 2);
    txn("wmis", 0, 1, 32'h12, 32'h11111111, 4'hF, 0, 1, 2);
    txn("r10c", 0, 0, 32'h10, 0, 4'h0, 32'hDEADAAEF, 0, 2);
    txn("rrng", 0, 0, 32'h400, 0, 4'h0, 0, 1, 2);
    txn("wnone", 0, 1, 32'h10, 32'h22222222, 4'h0, 0, 1, 2);
    txn("wbmis", 0, 1, 32'h13, 32'h33333333, 4'b0001, 0, 1, 2);
    txn("rmis", 0, 0, 32'h12, 0, 4'h0, 0, 1, 2);
    txn("whalf", 0, 1, 32'h10, 32'hFFFF0000, 4'b1100, 0, 0, 2);
    txn("r10d", 0, 0, 32'h10, 0, 4'h0, 32'hFFFFAAEF, 0, 2);

    base = rsp_seen;
    rv[0] = 1; wr[0] = 1; be[0] = 4'hF;
    for (int k = 0; k < 9; k++) begin
      ad[0] = 32'h40 + 32'(4 * k);
      wd[0] = 32'hA0000000 + 32'(k);
      @(posedge clk);
      #1;
    end
    rv[0] = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("hs_count", 32'(rsp_seen - base), 3);
    txn("r4c", 0, 0, 32'h4C, 0, 4'h0, 32'hA0000003, 0, 2);
    txn("r58", 0, 0, 32'h58, 0, 4'h0, 32'hA0000006, 0, 2);
    txn("r40", 0, 0, 32'h40, 0, 4'h0, 32'hA0000000, 0, 2);

    txn("ws0_w", 1, 1, 32'h8, 32'h12345678, 4'hF, 0, 0, 1);
    txn("ws0_r", 1, 0, 32'h8, 0, 4'h0, 32'h12345678, 0, 1);
    txn("ws0_e", 1, 0, 32'h9, 0, 4'h0, 0, 1, 1);
    txn("ws4_w", 2, 1, 32'h8, 32'hCAFEBABE, 4'hF, 0, 0, 5);
    txn("ws4_r", 2, 0, 32'h8, 0, 4'h0, 32'hCAFEBABE, 0, 5);

    txn("w20", 0, 1, 32'h20, 32'h0BADF00D, 4'hF, 0, 0, 2);
    txn("r20", 0, 0, 32'h20, 0, 4'h0, 32'h0BADF00D, 0, 2);
    issue(0, 1, 32'h20, 32'h55555555, 4'hF, acc);
    reset = 0;
    @(negedge clk);
    chk("rw_vld", 32'(rvld[0]), 0);
    chk("rw_rdata", rdata[0], 0);
    chk("rw_busy", 32'(bsy[0]), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;
    txn("r20b", 0, 0, 32'h20, 0, 4'h0, 32'h0BADF00D, 0, 2);

    issue(0, 1, 32'h24, 32'hCAFEF00D, 4'hF, acc);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rr_vld", 32'(rvld[0]), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;
    txn("r24", 0, 0, 32'h24, 0, 4'h0, 32'hCAFEF00D, 0, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
